// File: rtl/sonar_capture_pkg.sv
// Shared types for the sonar receive-side capture controller.
//   state_e : controller FSM states
//   cfg_t   : per-ping configuration as presented at trigger time
package sonar_capture_pkg;

    localparam int unsigned CntWDefault = 16;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StDelay   = 3'd1,
        StAlign   = 3'd2,
        StCapture = 3'd3,
        StFlush   = 3'd4
    } state_e;

    typedef struct packed {
        logic [CntWDefault-1:0] delay;
        logic [CntWDefault-1:0] capture;
        logic                   align_ws;
    } cfg_t;

endpackage

// File: rtl/sonar_capture_ctrl_axis_reg_slice.sv
// One-deep registered AXI-Stream stage (tdata/tuser/tlast).
//   clk_i, rst_i         : clock, synchronous active-high reset
//   load_i               : capture data_i/user_i/last_i into the register
//   data_i/user_i/last_i : beat to load
//   force_last_i         : set tlast on the beat currently held
//   tready_i             : downstream ready
//   tvalid_o/tdata_o/tuser_o/tlast_o : registered output beat
// load_i must only be asserted when the slot is free (!tvalid_o || tready_i).
module axis_reg_slice #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              user_i,
    input  logic              last_i,
    input  logic              force_last_i,
    input  logic              tready_i,
    output logic              tvalid_o,
    output logic [DATA_W-1:0] tdata_o,
    output logic              tuser_o,
    output logic              tlast_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              user_q;
    logic              last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            user_q  <= user_i;
            last_q  <= last_i;
        end else if (valid_q && tready_i) begin
            // Data left in place; only valid/last are cleared once accepted.
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (valid_q && force_last_i) begin
            last_q  <= 1'b1;
        end
    end

    assign tvalid_o = valid_q;
    assign tdata_o  = data_q;
    assign tuser_o  = user_q;
    assign tlast_o  = last_q;

endmodule

// File: rtl/sonar_capture_ctrl.sv
// Receive-side acquisition sequencer for one sonar ping.
//   m_axis_aclk/m_axis_arst : clock, synchronous active-high reset
//   cfg_*                   : delay/capture frame counts and WS-align, sampled at trigger
//   trigger/abort           : single-cycle control pulses
//   s_axis_*                : frames from the I2S receiver
//   m_axis_*                : captured packet to DMA/packetiser
//   busy/done/aborted       : status (done/aborted are one-cycle pulses)
module sonar_capture_ctrl
    import sonar_capture_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DATA_W = 64
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_arst,
    input  logic [CNT_W-1:0]  cfg_delay_frames,
    input  logic [CNT_W-1:0]  cfg_capture_frames,
    input  logic              cfg_align_ws,
    input  logic              trigger,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] ccnt_q, ccnt_d;
    logic             align_q, align_d;
    logic             beat_q, beat_d;    // at least one beat loaded this packet
    logic             pend_q, pend_d;    // abort seen with empty slot: next take closes
    logic             close_q, close_d;  // packet closing due to abort
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic take, load, in_last, force_last, slot_free;

    assign slot_free = !m_axis_tvalid || m_axis_tready;
    assign take      = s_axis_tvalid && s_axis_tready;

    always_comb begin
        s_axis_tready = 1'b0;
        unique case (state_q)
            StIdle:    s_axis_tready = 1'b1;
            // At dcnt==0 the next frame belongs to the capture, so hold it.
            StDelay:   s_axis_tready = (dcnt_q != '0);
            // A WS-aligned frame is left in the receiver as the first capture beat.
            StAlign:   s_axis_tready = !(s_axis_tvalid && s_axis_tuser);
            StCapture: s_axis_tready = (ccnt_q != '0) && slot_free && !(abort && !beat_q);
            default:   s_axis_tready = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        ccnt_d     = ccnt_q;
        align_d    = align_q;
        beat_d     = beat_q;
        pend_d     = pend_q;
        close_d    = close_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        load       = 1'b0;
        in_last    = 1'b0;
        force_last = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trigger && !abort) begin
                    dcnt_d  = cfg_delay_frames;
                    ccnt_d  = cfg_capture_frames;
                    align_d = cfg_align_ws;
                    beat_d  = 1'b0;
                    pend_d  = 1'b0;
                    close_d = 1'b0;
                    state_d = StDelay;
                end
            end
            StDelay: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end else if (dcnt_q == '0) begin
                    state_d = align_q ? StAlign : StCapture;
                end else if (take) begin
                    dcnt_d = dcnt_q - One;
                end
            end
            StAlign: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end else if (s_axis_tvalid && s_axis_tuser) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (ccnt_q == '0) begin
                    // Zero-length capture: nothing was ever loaded.
                    done_d    = !abort;
                    aborted_d = abort;
                    state_d   = StIdle;
                end else if (take) begin
                    load    = 1'b1;
                    beat_d  = 1'b1;
                    ccnt_d  = ccnt_q - One;
                    in_last = (ccnt_q == One) || pend_q || abort;
                    if (in_last) begin
                        close_d = pend_q || abort;
                        state_d = StFlush;
                    end
                end else if (abort && !pend_q) begin
                    if (!beat_q) begin
                        aborted_d = 1'b1;
                        state_d   = StIdle;
                    end else if (m_axis_tvalid && !m_axis_tready) begin
                        force_last = 1'b1;
                        close_d    = 1'b1;
                        state_d    = StFlush;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            StFlush: begin
                if (m_axis_tvalid && m_axis_tready) begin
                    done_d    = !close_q;
                    aborted_d = close_q;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_arst) begin
            state_q   <= StIdle;
            dcnt_q    <= '0;
            ccnt_q    <= '0;
            align_q   <= 1'b0;
            beat_q    <= 1'b0;
            pend_q    <= 1'b0;
            close_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            ccnt_q    <= ccnt_d;
            align_q   <= align_d;
            beat_q    <= beat_d;
            pend_q    <= pend_d;
            close_q   <= close_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    axis_reg_slice #(
        .DATA_W (DATA_W)
    ) u_slice (
        .clk_i        (m_axis_aclk),
        .rst_i        (m_axis_arst),
        .load_i       (load),
        .data_i       (s_axis_tdata),
        .user_i       (s_axis_tuser),
        .last_i       (in_last),
        .force_last_i (force_last),
        .tready_i     (m_axis_tready),
        .tvalid_o     (m_axis_tvalid),
        .tdata_o      (m_axis_tdata),
        .tuser_o      (m_axis_tuser),
        .tlast_o      (m_axis_tlast)
    );

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_sonar_capture_ctrl.sv
module tb_sonar_capture_ctrl;

    localparam int CW = 16;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cfg_delay, cfg_cap;
    logic          cfg_align, trig, abrt;
    logic [DW-1:0] s_data;
    logic          s_user, s_valid, s_ready;
    logic [DW-1:0] m_data;
    logic          m_user, m_last, m_valid, m_ready;
    logic          busy, done, aborted;

    always #5 clk = ~clk;

    sonar_capture_ctrl #(.CNT_W(CW), .DATA_W(DW)) dut (
        .m_axis_aclk        (clk),
        .m_axis_arst        (rst),
        .cfg_delay_frames   (cfg_delay),
        .cfg_capture_frames (cfg_cap),
        .cfg_align_ws       (cfg_align),
        .trigger            (trig),
        .abort              (abrt),
        .s_axis_tdata       (s_data),
        .s_axis_tuser       (s_user),
        .s_axis_tvalid      (s_valid),
        .s_axis_tready      (s_ready),
        .m_axis_tdata       (m_data),
        .m_axis_tuser       (m_user),
        .m_axis_tlast       (m_last),
        .m_axis_tvalid      (m_valid),
        .m_axis_tready      (m_ready),
        .busy               (busy),
        .done               (done),
        .aborted            (aborted)
    );

    typedef struct packed { logic [DW-1:0] d; logic u; logic l; } beat_t;
    typedef struct packed { logic [DW-1:0] d; logic u; } frm_t;

    beat_t exp_q[$];
    frm_t  src_q[$];
    int    tests = 0;
    int    fails = 0;
    int    rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by main process

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int t, input int i);
        logic [7:0] tb8, ib8;
        tb8 = t[7:0];
        ib8 = i[7:0];
        return {tb8, 48'h0, ib8};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frm(input logic [DW-1:0] d, input logic u);
        frm_t f;
        f.d = d;
        f.u = u;
        src_q.push_back(f);
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic u, input logic l);
        beat_t b;
        b.d = d;
        b.u = u;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic pulse_trig(input int d, input int c, input logic a);
        cfg_delay = CW'(d);
        cfg_cap   = CW'(c);
        cfg_align = a;
        trig      = 1'b1;
        step();
        trig      = 1'b0;
    endtask

    // Step until busy falls; then done/aborted must be pulsing in that same cycle.
    task automatic wait_end(input string name, input logic exp_done, input logic exp_abt);
        int k = 0;
        while (busy && k < 300) begin
            step();
            k++;
        end
        chk({name, "_busy_fall"}, {63'h0, busy}, 64'h0);
        chk({name, "_done"}, {63'h0, done}, {63'h0, exp_done});
        chk({name, "_aborted"}, {63'h0, aborted}, {63'h0, exp_abt});
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!m_valid && k < 100) begin
            step();
            k++;
        end
        chk({name, "_valid_seen"}, {63'h0, m_valid}, 64'h1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (src_q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        chk({name, "_src_drained"}, 64'(src_q.size()), 64'h0);
        step();
        step();
        chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'h0);
    endtask

    // Receiver model: presents queued frames, pops on handshake.
    initial begin
        logic took;
        s_valid = 1'b0;
        s_data  = '0;
        s_user  = 1'b0;
        forever begin
            @(negedge clk);
            took = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (took && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                s_valid = 1'b1;
                s_data  = src_q[0].d;
                s_user  = src_q[0].u;
            end else begin
                s_valid = 1'b0;
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) m_ready = 1'b1;
            else if (rdy_mode == 1) m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: scoreboard pop on output handshake, stall stability, backpressure.
    logic          stall_prev = 1'b0;
    logic [DW:0]   stall_val;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && m_valid)
                chk("stall_stable", 64'({m_user, m_data} != stall_val), 64'h0);
            if (m_valid && !m_ready)
                chk("backpressure_tready", {63'h0, s_ready}, 64'h0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", m_data, 64'hDEAD);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.d);
                    chk("beat_user", {63'h0, m_user}, {63'h0, e.u});
                    chk("beat_last", {63'h0, m_last}, {63'h0, e.l});
                end
            end
            stall_prev = m_valid && !m_ready;
            stall_val  = {m_user, m_data};
        end
    end

    initial begin
        rst = 1'b1;
        cfg_delay = '0;
        cfg_cap = '0;
        cfg_align = 1'b0;
        trig = 1'b0;
        abrt = 1'b0;
        step();
        step();
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_tvalid", {63'h0, m_valid}, 64'h0);
        chk("rst_tlast", {63'h0, m_last}, 64'h0);
        chk("rst_tuser", {63'h0, m_user}, 64'h0);
        chk("rst_tdata", m_data, 64'h0);
        chk("rst_done", {62'h0, done, aborted}, 64'h0);
        chk("rst_s_ready", {63'h0, s_ready}, 64'h1);
        rst = 1'b0;
        step();

        // 1: delay 3, capture 4, no align
        pulse_trig(3, 4, 1'b0);
        for (int i = 0; i < 10; i++) push_frm(mk(1, i), 1'b0);
        for (int i = 3; i < 7; i++) push_exp(mk(1, i), 1'b0, i == 6);
        wait_end("t1", 1'b1, 1'b0);
        drain("t1");

        // 2: delay 0, capture 2, align on WS
        pulse_trig(0, 2, 1'b1);
        push_frm(mk(2, 0), 1'b0);
        push_frm(mk(2, 1), 1'b0);
        push_frm(mk(2, 2), 1'b1);
        push_frm(mk(2, 3), 1'b0);
        push_exp(mk(2, 2), 1'b1, 1'b0);
        push_exp(mk(2, 3), 1'b0, 1'b1);
        wait_end("t2", 1'b1, 1'b0);
        drain("t2");

        // 3: capture 5 with random downstream stalls
        rdy_mode = 1;
        pulse_trig(0, 5, 1'b0);
        for (int i = 0; i < 7; i++) push_frm(mk(3, i), 1'(i & 1));
        for (int i = 0; i < 5; i++) push_exp(mk(3, i), 1'(i & 1), i == 4);
        wait_end("t3", 1'b1, 1'b0);
        rdy_mode = 0;
        drain("t3");

        // 4: capture 8, abort while 4th beat held
        rdy_mode = 2;
        m_ready = 1'b0;
        pulse_trig(0, 8, 1'b0);
        for (int i = 0; i < 8; i++) push_frm(mk(4, i), 1'b0);
        for (int i = 0; i < 4; i++) push_exp(mk(4, i), 1'b0, i == 3);
        wait_valid("t4");
        for (int i = 0; i < 3; i++) begin
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
        end
        abrt = 1'b1;
        step();
        abrt = 1'b0;
        chk("t4_flush_s_ready", {63'h0, s_ready}, 64'h0);
        chk("t4_flush_last", {62'h0, m_valid, m_last}, 64'h3);
        m_ready = 1'b1;
        wait_end("t4", 1'b0, 1'b1);
        rdy_mode = 0;
        drain("t4");

        // 5: retrigger in DELAY ignored; trigger+abort in IDLE
        pulse_trig(4, 2, 1'b0);
        pulse_trig(0, 5, 1'b1);
        for (int i = 0; i < 8; i++) push_frm(mk(5, i), 1'b0);
        push_exp(mk(5, 4), 1'b0, 1'b0);
        push_exp(mk(5, 5), 1'b0, 1'b1);
        wait_end("t5", 1'b1, 1'b0);
        drain("t5");
        abrt = 1'b1;
        pulse_trig(1, 1, 1'b0);
        abrt = 1'b0;
        chk("t5b_busy", {63'h0, busy}, 64'h0);
        chk("t5b_no_aborted", {63'h0, aborted}, 64'h0);
        step();
        chk("t5b_busy2", {62'h0, busy, aborted}, 64'h0);

        // 6: capture 0, then reset mid-capture
        pulse_trig(0, 0, 1'b0);
        wait_end("t6", 1'b1, 1'b0);
        rdy_mode = 2;
        m_ready = 1'b0;
        pulse_trig(0, 5, 1'b0);
        for (int i = 0; i < 5; i++) push_frm(mk(6, i), 1'b0);
        wait_valid("t6r");
        rst = 1'b1;
        src_q.delete();
        exp_q.delete();
        step();
        chk("t6r_tvalid", {63'h0, m_valid}, 64'h0);
        chk("t6r_tlast", {63'h0, m_last}, 64'h0);
        chk("t6r_tdata", m_data, 64'h0);
        chk("t6r_busy", {63'h0, busy}, 64'h0);
        chk("t6r_s_ready", {63'h0, s_ready}, 64'h1);
        rst = 1'b0;
        rdy_mode = 0;
        step();
        step();
        chk("final_sb_empty", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sonar_capture_ctrl.md
Name: sonar_capture_ctrl

Overview:
Sequences receive-side acquisition for one sonar ping. It sits between the I2S receiver's 64-bit AXI-Stream output and the downstream DMA/packetiser.
- Outside a capture it drains stale receiver FIFO data.
- On a trigger it discards a programmable number of frames (blanking), then forwards exactly N frames as one AXIS packet, with tlast on the final frame.
- It reports busy, done and abort status.

Parameters:
CNT_W, 16, width of the delay and capture frame counters and config inputs.
DATA_W, 64, AXIS tdata width (matches receiver output).

Ports:
m_axis_aclk  in  1  single clock; all logic on rising edge.
m_axis_arst  in  1  reset, synchronous, active-high.
cfg_delay_frames  in  CNT_W  frames to discard after trigger; sampled at trigger.
cfg_capture_frames  in  CNT_W  frames to forward; sampled at trigger; 0 means no capture.
cfg_align_ws  in  1  1 = first captured frame must have s_axis_tuser==1; sampled at trigger.
trigger  in  1  single-cycle start pulse (ping transmitted).
abort  in  1  single-cycle abort pulse.
s_axis_tdata  in  DATA_W  frame from the I2S receiver.
s_axis_tuser  in  1  WS phase of the frame.
s_axis_tvalid  in  1  receiver valid.
s_axis_tready  out  1  controller ready.
m_axis_tdata  out  DATA_W  forwarded frame.
m_axis_tuser  out  1  forwarded WS phase.
m_axis_tlast  out  1  last frame of the packet.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  downstream ready.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when a packet completes normally.
aborted  out  1  one-cycle pulse when a capture terminates via abort.

Behaviour:
- Reset values: state IDLE; all counters 0; m_axis_tvalid, m_axis_tlast, m_axis_tuser and m_axis_tdata 0; busy, done and aborted 0. Reset mid-packet drops the output register without emitting tlast.
- Input handshake: a frame is "taken" when s_axis_tvalid && s_axis_tready.
- Output stage: a single register slice.
  - s_axis_tready in CAPTURE = !m_axis_tvalid || m_axis_tready.
  - Forwarding latency is 1 cycle from take to m_axis_tvalid.
  - m_axis_* stay stable while tvalid && !tready.
- IDLE: s_axis_tready=1, input discarded. trigger latches the cfg_* values, loads dcnt=cfg_delay_frames and ccnt=cfg_capture_frames, and moves to DELAY.
- DELAY: s_axis_tready=1, frames discarded, dcnt decrements per take. When dcnt==0 at the start of a cycle, go to ALIGN if align is latched, otherwise CAPTURE. cfg_delay_frames=0 passes straight through with 0 frames discarded.
- ALIGN: s_axis_tready=1. A take with tuser==0 is discarded. A frame with tvalid && tuser==1 is not consumed (tready=0 that cycle); the state moves to CAPTURE so that frame is the first captured.
- CAPTURE:
  - Each take loads the output register and decrements ccnt.
  - The take with ccnt==1 sets tlast=1 and moves to FLUSH.
  - ccnt==0 on entry skips directly to done with no beats emitted.
- FLUSH: s_axis_tready=0. When the output handshake completes, pulse done and return to IDLE.
- Trigger handling: trigger while busy is ignored (no relatch, no restart). trigger and abort in the same IDLE cycle: abort wins; stay IDLE with no aborted pulse.
- Abort in DELAY or ALIGN: return to IDLE next cycle and pulse aborted.
- Abort in CAPTURE with no beat yet emitted: to IDLE, pulse aborted.
- Abort in CAPTURE after at least one beat: the packet must be closed.
  - If the output register is holding an unaccepted beat, force its tlast=1.
  - Otherwise the next taken frame carries tlast=1.
  - Then FLUSH; on completion pulse aborted instead of done.
- Abort in FLUSH: ignored (packet already closing); done pulses normally.
- Counters are CNT_W wide, count down, and never wrap. Maximum 2^CNT_W−1 frames per phase.

Decomposition:
- Package sonar_capture_pkg: state enum (IDLE, DELAY, ALIGN, CAPTURE, FLUSH) and a typedef for the cfg struct {delay, capture, align_ws}.
- One natural sub-module: axis_reg_slice, the 1-deep registered AXIS stage with tdata/tuser/tlast and a force_last input.
- FSM and counters stay in the top module.

Test Plan:
- delay=3, capture=4, align=0, tready=1, frames D0..D9 back-to-back, trigger before D0 → D0-D2 dropped; output D3,D4,D5,D6 with tlast on D6; done pulses 1 cycle after D6 handshake; busy falls the same cycle.
- delay=0, capture=2, align=1, tuser pattern 0,0,1,0 on D0..D3 → D0 and D1 dropped; output D2 (tuser=1) and D3 (tlast).
- capture=5, random m_axis_tready at 50% duty → 5 beats in order, data stable while stalled, exactly one tlast, s_axis_tready=0 whenever the register is full and downstream is not ready.
- capture=8, abort after 3rd output beat while the 4th is held with tready=0 → 4th beat emitted with tlast=1; aborted pulse, no done; 5th input frame not taken.
- trigger issued in DELAY with different cfg → ignored; original counts honoured. trigger+abort in the same IDLE cycle → remains IDLE, busy=0.
- capture=0 → no output beats; done pulses. Assert reset in CAPTURE → all outputs 0 next cycle, state IDLE, s_axis_tready=1.
